alu_op_sequencer: RTL

- Multi-cycle controller that sequences one ALU operation per request over the shared 32-bit internal bus.
- Per operation: loads Y with operand A, presents operand B and the 4-bit ALU control code, waits extra settle cycles for mul/div, captures the 64-bit Z result, then returns it over a valid/ready response.
- Sits between the control unit (requester) and the ALU with its Y/Z registers.
- Only one operation is in flight at any time.

---
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller that runs one ALU operation per request over the
// shared internal bus. It loads Y with operand A, presents operand B with the
// ALU control code, holds extra settle cycles for mul/div, captures the
// 2*REG_SIZE-bit Z result and returns it through a valid/ready response.
//
// Optional build macro: ALU_SEQ_DIV0_CHECK_EN
//   defined   - a div whose B operand is zero is answered immediately with
//               rsp_err=1, rsp_lo=all ones, rsp_hi=0, and no Y/Z strobes.
//   undefined - div by zero runs the normal sequence like any other div.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   req_valid  request present          req_ready  accepting (IDLE only)
//   req_op     4-bit ALU op code        req_a/b    operands A and B
//   bus_data   value driven onto the ALU bus input
//   y_load     Y register load strobe   alu_ctrl   ALU control code
//   z_load     Z register load strobe   z_data_in  ALU result (2*REG_SIZE)
//   rsp_valid  result available         rsp_ready  consumer accepts result
//   rsp_lo/hi  result low/high word     rsp_err    illegal op or div-by-zero
module alu_op_sequencer #(
  parameter int unsigned REG_SIZE     = 32,
  parameter int unsigned MUL_DIV_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [REG_SIZE-1:0]   req_a,
  input  logic [REG_SIZE-1:0]   req_b,
  output logic [REG_SIZE-1:0]   bus_data,
  output logic                  y_load,
  output logic [3:0]            alu_ctrl,
  output logic                  z_load,
  input  logic [2*REG_SIZE-1:0] z_data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_SIZE-1:0]   rsp_lo,
  output logic [REG_SIZE-1:0]   rsp_hi,
  output logic                  rsp_err
);

  localparam int unsigned CW = (MUL_DIV_WAIT > 0) ? $clog2(MUL_DIV_WAIT + 1) : 1;
  localparam logic [3:0]  OP_MUL = 4'b1000;
  localparam logic [3:0]  OP_DIV = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_Y,
    EXEC,
    RESP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           op_q;
  logic [REG_SIZE-1:0]  a_q;
  logic [REG_SIZE-1:0]  b_q;
  logic [CW-1:0]        cnt;
  logic                 cnt_zero;
  logic                 op_illegal;
  logic                 div_zero;

  assign cnt_zero   = (cnt == '0);
  assign op_illegal = req_op[3] & req_op[2];

`ifdef ALU_SEQ_DIV0_CHECK_EN
  // Checked on the accept edge, i.e. against the B value being latched.
  assign div_zero = (req_op == OP_DIV) && (req_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  // alu_ctrl only follows ops that actually reach the ALU, so it keeps the
  // last executed op through error responses and idle periods.
  assign alu_ctrl = op_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    y_load    = 1'b0;
    z_load    = 1'b0;
    bus_data  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = (op_illegal || div_zero) ? RESP : LOAD_Y;
        end
      end
      LOAD_Y: begin
        y_load    = 1'b1;
        bus_data  = a_q;
        state_nxt = EXEC;
      end
      EXEC: begin
        bus_data = b_q;
        z_load   = cnt_zero;
        if (cnt_zero) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      rsp_lo  <= '0;
      rsp_hi  <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q <= req_a;
            b_q <= req_b;
            if (op_illegal) begin
              rsp_err <= 1'b1;
              rsp_lo  <= '0;
              rsp_hi  <= '0;
            end else if (div_zero) begin
              rsp_err <= 1'b1;
              rsp_lo  <= '1;
              rsp_hi  <= '0;
            end else begin
              op_q <= req_op;
            end
          end
        end
        LOAD_Y: begin
          cnt <= ((op_q == OP_MUL) || (op_q == OP_DIV)) ? CW'(MUL_DIV_WAIT) : '0;
        end
        EXEC: begin
          if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_lo  <= z_data_in[REG_SIZE-1:0];
            rsp_hi  <= (op_q == OP_MUL) ? z_data_in[2*REG_SIZE-1:REG_SIZE] : '0;
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
